// File: rtl/mult_div_unit_pkg.sv
// Shared CPU constants for the multiply/divide unit: op encodings, FSM states
// and default busy-cycle counts.
package mult_div_unit_pkg;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  localparam int MDU_MULT_CYCLES = 5;
  localparam int MDU_DIV_CYCLES  = 10;

  // ops 0-3 occupy the unit for a multi-cycle busy window
  function automatic logic mdu_is_long(input logic [2:0] op);
    return (op[2] == 1'b0);
  endfunction

endpackage

// File: rtl/mult_div_unit.sv
// MIPS-style HI/LO multiply/divide unit: result computed combinationally at
// accept, held in pending registers, committed after a fixed busy window.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int MULT_CYCLES = MDU_MULT_CYCLES,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  mdu_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [31:0]   hi_q, lo_q;
  logic [63:0]   pend_q;
  logic          busy_q;

  // arithmetic
  logic [63:0] prod_s, prod_u, res;
  logic        sdiv;
  logic [31:0] a_mag, b_mag, b_den, uq, ur, quo, rem;

  assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
  assign prod_u = {32'd0, A} * {32'd0, B};

  // one unsigned divider on magnitudes; signs restored afterwards so that
  // 0x80000000 / -1 wraps to 0x80000000 with zero remainder
  assign sdiv  = (op == MDU_DIV);
  assign a_mag = (sdiv && A[31]) ? -A : A;
  assign b_mag = (sdiv && B[31]) ? -B : B;
  assign b_den = (B == 32'd0) ? 32'd1 : b_mag;
  assign uq    = a_mag / b_den;
  assign ur    = a_mag % b_den;
  assign quo   = (sdiv && (A[31] ^ B[31])) ? -uq : uq;
  assign rem   = (sdiv && A[31]) ? -ur : ur;

  always_comb begin
    res = {hi_q, lo_q};
    case (op)
      MDU_MULT:  res = prod_s;
      MDU_MULTU: res = prod_u;
      MDU_DIV, MDU_DIVU: if (B != 32'd0) res = {rem, quo};
      default:   res = {hi_q, lo_q};
    endcase
  end

  // FSM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start && mdu_is_long(op)) state_d = ST_RUN;
      ST_RUN:  if (cnt_q == CW'(1))          state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // datapath; starts seen outside IDLE (including the commit edge) are dropped
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      pend_q <= '0;
    end else if (state_q == ST_IDLE) begin
      if (start) begin
        case (op)
          MDU_MULT, MDU_MULTU: begin
            pend_q <= res;
            cnt_q  <= CW'(MULT_CYCLES);
            busy_q <= 1'b1;
          end
          MDU_DIV, MDU_DIVU: begin
            pend_q <= res;
            cnt_q  <= CW'(DIV_CYCLES);
            busy_q <= 1'b1;
          end
          MDU_MTHI: hi_q <= A;
          MDU_MTLO: lo_q <= A;
          default: ;
        endcase
      end
    end else begin
      cnt_q <= cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        {hi_q, lo_q} <= pend_q;
        busy_q       <= 1'b0;
      end
    end
  end

  assign busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: stimulus pushes expected commits into a
// queue, a negedge monitor checks busy length and HI/LO when busy falls.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A, B;
  logic        busy;
  logic [31:0] HI, LO;

  mult_div_unit dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
    .busy(busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  id;
    logic [7:0]  cyc;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor: measures each busy window and checks the commit it ends with
  initial begin
    int          run_len;
    logic        hold_bad;
    logic [31:0] h0, l0;
    exp_t        e;
    run_len  = 0;
    hold_bad = 1'b0;
    h0 = '0;
    l0 = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        run_len  = 0;
        hold_bad = 1'b0;
      end else if (busy) begin
        if (run_len == 0) begin
          h0 = HI;
          l0 = LO;
        end else if (HI !== h0 || LO !== l0) hold_bad = 1'b1;
        run_len++;
      end else if (run_len > 0) begin
        chk("commit_expected", q.size(), 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          chk($sformatf("op%0d_busy_cycles", e.id), run_len, {24'd0, e.cyc});
          chk($sformatf("op%0d_hi", e.id), HI, e.hi);
          chk($sformatf("op%0d_lo", e.id), LO, e.lo);
          chk($sformatf("op%0d_hold_during_run", e.id), {31'd0, hold_bad}, 0);
        end
        run_len  = 0;
        hold_bad = 1'b0;
      end
    end
  end

  task automatic pulse(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk);
    #1 start = 1'b1; op = o; A = a; B = b;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic issue(input logic [7:0] id, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [7:0] cyc,
                       input logic [31:0] eh, input logic [31:0] el);
    exp_t e;
    e.id = id; e.cyc = cyc; e.hi = eh; e.lo = el;
    q.push_back(e);
    pulse(o, a, b);
  endtask

  task automatic wait_idle(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) chk({name, "_timeout"}, 32'd1, 32'd0);
  endtask

  initial begin
    logic seen;
    reset = 1'b0; start = 1'b0; op = 3'd0; A = '0; B = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", {31'd0, busy}, 0);
    chk("reset_hi", HI, 0);
    chk("reset_lo", LO, 0);
    @(negedge clk) reset = 1'b1;

    issue(1, 3'd0, 32'hFFFFFFFE, 32'd3, 5, 32'hFFFFFFFF, 32'hFFFFFFFA);
    wait_idle("mult");
    issue(2, 3'd1, 32'hFFFFFFFF, 32'd2, 5, 32'h00000001, 32'hFFFFFFFE);
    wait_idle("multu");
    issue(3, 3'd2, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    wait_idle("div");
    issue(4, 3'd3, 32'd7, 32'd0, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    wait_idle("divu_zero");
    issue(5, 3'd2, 32'h80000000, 32'hFFFFFFFF, 10, 32'h0, 32'h80000000);
    wait_idle("div_ovf");
    issue(6, 3'd3, 32'd100, 32'd7, 10, 32'd2, 32'd14);
    wait_idle("divu");
    issue(7, 3'd2, 32'd7, 32'hFFFFFFFE, 10, 32'd1, 32'hFFFFFFFD);
    wait_idle("div_negb");

    // MTLO during RUN must be dropped
    issue(8, 3'd0, 32'h00010000, 32'h00010000, 5, 32'd1, 32'd0);
    @(posedge clk);
    #1 start = 1'b1; op = 3'd5; A = 32'd5;
    @(posedge clk);
    #1 start = 1'b0;
    wait_idle("mult_mtlo_run");

    pulse(3'd5, 32'd5, 32'd0);
    chk("mtlo_lo", LO, 32'd5);
    chk("mtlo_hi_kept", HI, 32'd1);
    seen = busy;
    repeat (3) begin
      @(negedge clk);
      seen = seen | busy;
    end
    chk("mtlo_no_busy", {31'd0, seen}, 0);

    // start coinciding with the commit edge is ignored
    issue(9, 3'd0, 32'd3, 32'd4, 5, 32'd0, 32'd12);
    repeat (4) @(posedge clk);
    #1 start = 1'b1; op = 3'd3; A = 32'd9; B = 32'd2;
    @(posedge clk);
    #1 start = 1'b0;
    chk("fall_start_busy0", {31'd0, busy}, 0);
    @(posedge clk);
    #1 chk("fall_start_busy1", {31'd0, busy}, 0);

    pulse(3'd4, 32'hDEADBEEF, 32'd0);
    chk("mthi_hi", HI, 32'hDEADBEEF);
    chk("mthi_lo_kept", LO, 32'd12);

    pulse(3'd6, 32'h1234, 32'h5678);
    chk("rsvd_busy", {31'd0, busy}, 0);
    chk("rsvd_hi", HI, 32'hDEADBEEF);
    chk("rsvd_lo", LO, 32'd12);

    // reset during busy cycle 4 of a DIV
    issue(10, 3'd2, 32'd100, 32'd3, 10, 32'd1, 32'd33);
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    q.delete();
    #1;
    chk("rst_mid_busy", {31'd0, busy}, 0);
    chk("rst_mid_hi", HI, 0);
    chk("rst_mid_lo", LO, 0);
    @(negedge clk) reset = 1'b1;
    seen = 1'b0;
    repeat (15) begin
      @(negedge clk);
      seen = seen | busy;
    end
    chk("rst_after_busy", {31'd0, seen}, 0);
    chk("rst_after_hi", HI, 0);
    chk("rst_after_lo", LO, 0);
    chk("queue_drained", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have parameter MULT_CYCLES, default 5: busy cycles for MULT/MULTU.
REQ-002 The block SHALL have parameter DIV_CYCLES, default 10: busy cycles for DIV/DIVU.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: EX-stage request to execute op this cycle.
REQ-006 The block SHALL have port op, input, 3 bits: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 reserved.
REQ-007 The block SHALL have port A, input, 32 bits: forwarded rs operand (ALU operand path).
REQ-008 The block SHALL have port B, input, 32 bits: forwarded rt operand.
REQ-009 The block SHALL have port busy, output, 1 bit: high while a mult/div operation is in flight.
REQ-010 The block SHALL have port HI, output, 32 bits: architectural HI register, feeds MFHI result into the EX/MEM write-data path.
REQ-011 The block SHALL have port LO, output, 32 bits: architectural LO register, feeds MFLO result into the EX/MEM write-data path.

Function
REQ-012 The FSM SHALL have two states: IDLE and RUN.
REQ-013 start SHALL be accepted only in IDLE; start while in RUN SHALL be ignored, with no effect on state, counter or HI/LO.
REQ-014 On an accepted start with op 0-3, the block SHALL latch the computed 64-bit result into internal pending registers, load the counter with MULT_CYCLES or DIV_CYCLES, and enter RUN at that edge.
REQ-015 busy SHALL be registered: it goes high in the cycle after the accepting edge and stays high for exactly N cycles (N = MULT_CYCLES or DIV_CYCLES).
REQ-016 At the edge ending the Nth busy cycle, the block SHALL commit pending {hi,lo} to HI/LO, drop busy and return to IDLE.
REQ-017 HI/LO SHALL hold their old values throughout RUN; new values become visible the same cycle busy is low.
REQ-018 The hazard unit SHALL stall any MDU-using instruction in D while (start | busy); the block itself performs no stall logic.
REQ-019 MULT SHALL produce the signed 32x32 product with {HI,LO} = full 64-bit result.
REQ-020 MULTU SHALL produce the unsigned 32x32 product with {HI,LO} = full 64-bit result.
REQ-021 DIV SHALL produce signed quotient in LO and remainder in HI: quotient truncated toward zero, remainder sign follows dividend A.
REQ-022 DIVU SHALL produce unsigned quotient in LO and remainder in HI.
REQ-023 For DIV of 0x80000000 / 0xFFFFFFFF, the result SHALL be LO=0x80000000, HI=0.
REQ-024 A DIV or DIVU with B=0 SHALL still run DIV_CYCLES busy cycles, and HI and LO SHALL both remain unchanged at commit.
REQ-025 MTHI/MTLO accepted in IDLE SHALL write A to HI or LO at that edge and SHALL NOT assert busy (zero-latency).
REQ-026 A reserved op with start SHALL be a no-op.
REQ-027 A start in the same cycle that busy falls (RUN→IDLE edge) SHALL be ignored; the next request must arrive while in IDLE.

Reset
REQ-028 While reset is low, state SHALL be IDLE, counter 0, busy 0, HI 0, LO 0 and pending registers 0, asynchronously, including mid-operation.
REQ-029 An in-flight operation interrupted by reset SHALL be discarded; after reset releases, HI/LO remain 0 until the next commit.

Structure
REQ-030 Op encodings (MDU_MULT..MDU_MTLO) and default cycle counts SHALL live in the shared CPU constants package used by the controller and hazard unit.
REQ-031 The block SHALL be a single module with no sub-module: arithmetic is combinational (synthesis operators), and the counter/FSM is local.

Verification
REQ-032 MULT A=0xFFFFFFFE (-2), B=3, start 1 cycle → busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-033 MULTU A=0xFFFFFFFF, B=2 → after 5 busy cycles HI=0x00000001, LO=0xFFFFFFFE.
REQ-034 DIV A=0xFFFFFFF9 (-7), B=2 → busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7/0 afterwards → 10 busy cycles, HI/LO unchanged.
REQ-035 MULT started, second start (MTLO A=5) asserted during RUN → ignored: LO equals the product, not 5; a subsequent MTLO in IDLE sets LO=5 with busy never high.
REQ-036 DIV started, reset pulled low at busy cycle 4 → busy, HI and LO are 0 immediately; no commit occurs after release.
